// File: rtl/serial_sub4_if.sv
// Handshake, operand and result bundle for the bit-serial 4-bit subtractor.
interface serial_sub4_if;
    logic start;
    logic a1, a2, a3, a4;
    logic b1, b2, b3, b4;
    logic bin;
    logic busy;
    logic done;
    logic d1, d2, d3, d4;
    logic bout;
    logic ovf;

    modport master (
        output start, a1, a2, a3, a4, b1, b2, b3, b4, bin,
        input  busy, done, d1, d2, d3, d4, bout, ovf
    );

    modport slave (
        input  start, a1, a2, a3, a4, b1, b2, b3, b4, bin,
        output busy, done, d1, d2, d3, d4, bout, ovf
    );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor: D = A - B - bin via one full-adder slice (A + ~B + ~bin),
// LSB first over four SHIFT cycles, with start/busy/done handshake.
module serial_sub4 #(
    parameter int unsigned HOLD_OPERANDS = 1
) (
    input logic         clk,
    input logic         rst,
    serial_sub4_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] a_cur;
    logic [3:0] b_cur;
    logic [3:0] result;
    logic [3:0] d_q;
    logic [1:0] idx;
    logic       carry;
    logic       bout_q;
    logic       ovf_q;
    logic       take;
    logic       a_bit;
    logic       nb_bit;
    logic       sum;
    logic       carry_next;

    // Slice inputs come from the captured copy or straight from the ports.
    always_comb begin
        a_cur      = (HOLD_OPERANDS != 0) ? a_q : {bus.a4, bus.a3, bus.a2, bus.a1};
        b_cur      = (HOLD_OPERANDS != 0) ? b_q : {bus.b4, bus.b3, bus.b2, bus.b1};
        a_bit      = a_cur[idx];
        nb_bit     = ~b_cur[idx];
        sum        = a_bit ^ nb_bit ^ carry;
        carry_next = (a_bit & nb_bit) | (a_bit & carry) | (nb_bit & carry);
        take       = bus.start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (idx == 2'd3) state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = (state == DONE);
        bus.d1   = d_q[0];
        bus.d2   = d_q[1];
        bus.d3   = d_q[2];
        bus.d4   = d_q[3];
        bus.bout = bout_q;
        bus.ovf  = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            d_q    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (take) begin
            a_q   <= {bus.a4, bus.a3, bus.a2, bus.a1};
            b_q   <= {bus.b4, bus.b3, bus.b2, bus.b1};
            carry <= ~bus.bin;
            idx   <= '0;
        end else if (state == SHIFT) begin
            result[idx] <= sum;
            carry       <= carry_next;
            idx         <= idx + 2'd1;
            // On the MSB, carry still holds the carry into bit 3 used for overflow.
            if (idx == 2'd3) begin
                d_q    <= {sum, result[2:0]};
                bout_q <= ~carry_next;
                ovf_q  <= carry ^ carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// Directed self-checking bench for serial_sub4 with hand-computed expected results.
module tb_serial_sub4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_sub4_if bus ();

    serial_sub4 #(.HOLD_OPERANDS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] d_obs;
    assign d_obs = {bus.d4, bus.d3, bus.d2, bus.d1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_ops(input logic [3:0] a, input logic [3:0] b, input logic bi);
        bus.a1 = a[0]; bus.a2 = a[1]; bus.a3 = a[2]; bus.a4 = a[3];
        bus.b1 = b[0]; bus.b2 = b[1]; bus.b3 = b[2]; bus.b4 = b[3];
        bus.bin = bi;
    endtask

    // Pulses start for one edge and waits (bounded) for done; returns the done
    // cycle index after the start edge and the number of busy cycles seen.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          output int lat, output int busy_cnt);
        drive_ops(a, b, bi);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) lat = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        drive_ops(4'h0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (d_obs !== 4'h0) begin errors++; $display("FAIL reset_d got %b want 0000", d_obs); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bus.bout); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(4'b0111, 4'b0011, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
        checks++; if (d_obs !== 4'b0100) begin errors++; $display("FAIL basic_d got %b want 0100", d_obs); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %b want 0", bus.bout); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", bus.ovf); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", bus.done); end
        checks++; if (d_obs !== 4'b0100) begin errors++; $display("FAIL basic_d_hold got %b want 0100", d_obs); end
    endtask

    task automatic test_borrow();
        int lat, bc;
        run_op(4'b0011, 4'b0111, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL borrow_latency got %0d want 4", lat); end
        checks++; if (d_obs !== 4'b1100) begin errors++; $display("FAIL borrow_d got %b want 1100", d_obs); end
        checks++; if (bus.bout !== 1'b1) begin errors++; $display("FAIL borrow_bout got %b want 1", bus.bout); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL borrow_ovf got %b want 0", bus.ovf); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(4'b1000, 4'b0001, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got %0d want 4", lat); end
        checks++; if (d_obs !== 4'b0111) begin errors++; $display("FAIL ovf_d got %b want 0111", d_obs); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL ovf_bout got %b want 0", bus.bout); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_ovf got %b want 1", bus.ovf); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1;
        second = -1;
        drive_ops(4'b0101, 4'b0101, 1'b1);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_ops(4'b1111, 4'b0000, 1'b0);
        for (int k = 0; k < 16 && second < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (first >= 0 && k == first + 1) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle busy got %b want 1", bus.busy); end
            end
            if (bus.done) begin
                if (first < 0) begin
                    first = k;
                    checks++; if (d_obs !== 4'b1111) begin errors++; $display("FAIL b2b_first_d got %b want 1111", d_obs); end
                    checks++; if (bus.bout !== 1'b1) begin errors++; $display("FAIL b2b_first_bout got %b want 1", bus.bout); end
                    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL b2b_first_ovf got %b want 0", bus.ovf); end
                end else begin
                    second = k;
                    bus.start = 1'b0;
                    checks++; if (d_obs !== 4'b1111) begin errors++; $display("FAIL b2b_second_d got %b want 1111", d_obs); end
                    checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL b2b_second_bout got %b want 0", bus.bout); end
                    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL b2b_second_ovf got %b want 0", bus.ovf); end
                end
            end
        end
        bus.start = 1'b0;
        checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first_latency got %0d want 4", first); end
        checks++; if (second !== 9) begin errors++; $display("FAIL b2b_second_latency got %0d want 9", second); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int ndone, at;
        ndone = 0;
        at = -1;
        drive_ops(4'b0111, 4'b0011, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (at < 0) at = k;
                checks++; if (d_obs !== 4'b0100) begin errors++; $display("FAIL busy_start_d got %b want 0100", d_obs); end
            end
            if (k == 1) begin
                drive_ops(4'b0000, 4'b0001, 1'b0);
                bus.start = 1'b1;
            end
            if (k == 2) bus.start = 1'b0;
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
        checks++; if (at !== 4) begin errors++; $display("FAIL busy_start_latency got %0d want 4", at); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, ndone;
        run_op(4'b0111, 4'b1111, 1'b0, lat, bc);
        checks++; if (d_obs !== 4'b1000) begin errors++; $display("FAIL pre_reset_d got %b want 1000", d_obs); end
        checks++; if (bus.bout !== 1'b1) begin errors++; $display("FAIL pre_reset_bout got %b want 1", bus.bout); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL pre_reset_ovf got %b want 1", bus.ovf); end
        @(negedge clk);
        drive_ops(4'b0011, 4'b0111, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        checks++; if (d_obs !== 4'h0) begin errors++; $display("FAIL midrst_d got %b want 0000", d_obs); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %b want 0", bus.bout); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", bus.ovf); end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_activity got %0d want 0", ndone); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        drive_ops(4'h0, 4'h0, 1'b0);
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
